// File: rtl/cb_harq_combine_engine_pkg.sv
// Shared types and helpers for the HARQ combine engine: one-hot states, default
// widths and the per-lane saturating LLR add.
package cb_harq_combine_engine_pkg;

    localparam int unsigned LLR_W_DEF        = 8;
    localparam int unsigned LLR_PER_WORD_DEF = 4;
    localparam int unsigned ADDR_W_DEF       = 11;
    localparam int unsigned USER_NUM_DEF     = 8;
    localparam int unsigned USER_W           = 3;
    localparam int unsigned IDX_W            = 4;

    localparam logic [IDX_W-1:0] USER_IDX_INVALID = 4'hF;

    typedef enum logic [7:0] {
        StIdle    = 8'b0000_0001,
        StLoad    = 8'b0000_0010,
        StRead    = 8'b0000_0100,
        StDrain   = 8'b0000_1000,
        StDone    = 8'b0001_0000,
        StWaitRel = 8'b0010_0000
    } state_e;

    // Symmetric clamp: the most negative code is never produced.
    localparam logic signed [LLR_W_DEF:0] SUM_MAX = (LLR_W_DEF + 1)'(2 ** (LLR_W_DEF - 1) - 1);
    localparam logic signed [LLR_W_DEF:0] SUM_MIN = -SUM_MAX;

    function automatic logic [LLR_W_DEF-1:0] sat_add(input logic [LLR_W_DEF-1:0] a,
                                                     input logic [LLR_W_DEF-1:0] b);
        logic signed [LLR_W_DEF:0] s;
        s = $signed({a[LLR_W_DEF-1], a}) + $signed({b[LLR_W_DEF-1], b});
        if (s > SUM_MAX) begin
            s = SUM_MAX;
        end else if (s < SUM_MIN) begin
            s = SUM_MIN;
        end
        return s[LLR_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/cb_harq_combine_engine_adder.sv
// Per-lane registered saturating LLR combiner; bypass passes the new LLR through
// unclamped. Latency is one cycle.
module harq_llr_sat_adder
    import cb_harq_combine_engine_pkg::*;
#(
    parameter int unsigned LLR_W        = LLR_W_DEF,
    parameter int unsigned LLR_PER_WORD = LLR_PER_WORD_DEF
) (
    input  logic                          i_core_clk,
    input  logic                          i_rx_rstn,
    input  logic                          i_bypass,
    input  logic [LLR_W*LLR_PER_WORD-1:0] i_llr_new,
    input  logic [LLR_W*LLR_PER_WORD-1:0] i_llr_old,
    output logic [LLR_W*LLR_PER_WORD-1:0] o_llr_sum
);

    logic [LLR_W*LLR_PER_WORD-1:0] sum_d;

    always_comb begin
        sum_d = '0;
        for (int l = 0; l < int'(LLR_PER_WORD); l++) begin
            sum_d[l*LLR_W +: LLR_W] = i_bypass ? i_llr_new[l*LLR_W +: LLR_W]
                                    : sat_add(i_llr_new[l*LLR_W +: LLR_W],
                                              i_llr_old[l*LLR_W +: LLR_W]);
        end
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            o_llr_sum <= '0;
        end else begin
            o_llr_sum <= sum_d;
        end
    end

endmodule

// File: rtl/cb_harq_combine_engine.sv
// Reads one user's codeblock from the ping-pong input buffer, soft-combines it with
// the stored HARQ LLRs, writes the result back and pulses completion.
module cb_harq_combine_engine
    import cb_harq_combine_engine_pkg::*;
#(
    parameter int unsigned LLR_W        = LLR_W_DEF,
    parameter int unsigned LLR_PER_WORD = LLR_PER_WORD_DEF,
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned USER_NUM     = USER_NUM_DEF
) (
    input  logic                          i_core_clk,
    input  logic                          i_rx_rstn,
    input  logic                          i_combine_process_request,
    input  logic [3:0]                    i_combine_user_index,
    input  logic [USER_NUM-1:0]           i_pingpong_indicator,
    input  logic [USER_NUM-1:0]           i_harq_first_tx,
    input  logic [USER_NUM*ADDR_W-1:0]    i_cb_word_num,
    output logic                          o_inbuf_rd_en,
    output logic [ADDR_W+3:0]             o_inbuf_rd_addr,
    input  logic [LLR_W*LLR_PER_WORD-1:0] i_inbuf_rd_data,
    output logic                          o_harq_rd_en,
    output logic [ADDR_W+2:0]             o_harq_rd_addr,
    input  logic [LLR_W*LLR_PER_WORD-1:0] i_harq_rd_data,
    output logic                          o_harq_wr_en,
    output logic [ADDR_W+2:0]             o_harq_wr_addr,
    output logic [LLR_W*LLR_PER_WORD-1:0] o_harq_wr_data,
    output logic                          o_current_cb_combine_comp,
    output logic                          o_busy,
    output logic                          o_err_bad_user
);

    state_e              state_q;
    logic [USER_W-1:0]   user_q;
    logic                pp_q;
    logic                first_q;
    logic                bad_q;
    logic                drain_q;
    logic [ADDR_W-1:0]   num_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic                inbuf_rd_en_q;
    logic [ADDR_W+3:0]   inbuf_rd_addr_q;
    logic                harq_rd_en_q;
    logic [ADDR_W+2:0]   harq_rd_addr_q;
    logic                vld_d1_q;
    logic [ADDR_W-1:0]   off_d1_q;
    logic                wr_en_q;
    logic [ADDR_W+2:0]   wr_addr_q;
    logic                comp_q;
    logic                err_q;

    logic [USER_W-1:0]   ld_user;
    logic [ADDR_W-1:0]   ld_num;
    logic                ld_pp;
    logic                ld_first;
    logic                idx_bad;

    always_comb begin
        ld_user  = i_combine_user_index[USER_W-1:0];
        ld_num   = i_cb_word_num[ld_user*ADDR_W +: ADDR_W];
        ld_pp    = i_pingpong_indicator[ld_user];
        ld_first = i_harq_first_tx[ld_user];
        idx_bad  = i_combine_user_index > 4'(USER_NUM - 1);
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state_q         <= StIdle;
            user_q          <= '0;
            pp_q            <= 1'b0;
            first_q         <= 1'b0;
            bad_q           <= 1'b0;
            drain_q         <= 1'b0;
            num_q           <= '0;
            cnt_q           <= '0;
            inbuf_rd_en_q   <= 1'b0;
            inbuf_rd_addr_q <= '0;
            harq_rd_en_q    <= 1'b0;
            harq_rd_addr_q  <= '0;
            vld_d1_q        <= 1'b0;
            off_d1_q        <= '0;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= '0;
            comp_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            comp_q    <= 1'b0;
            err_q     <= 1'b0;
            // Write pipeline trails the read strobe by two cycles (RAM + adder).
            vld_d1_q  <= inbuf_rd_en_q;
            off_d1_q  <= inbuf_rd_addr_q[ADDR_W-1:0];
            wr_en_q   <= vld_d1_q;
            wr_addr_q <= {user_q, off_d1_q};
            unique case (state_q)
                StIdle: begin
                    if (i_combine_process_request) begin
                        state_q <= StLoad;
                        bad_q   <= idx_bad;
                        err_q   <= idx_bad;
                    end
                end
                StLoad: begin
                    user_q  <= ld_user;
                    pp_q    <= ld_pp;
                    first_q <= ld_first;
                    num_q   <= ld_num;
                    cnt_q   <= '0;
                    if (bad_q || ld_num == '0) begin
                        state_q <= StDone;
                        comp_q  <= 1'b1;
                    end else begin
                        // Offset 0 is issued here so READ lasts exactly N cycles.
                        state_q         <= StRead;
                        inbuf_rd_en_q   <= 1'b1;
                        harq_rd_en_q    <= !ld_first;
                        inbuf_rd_addr_q <= {ld_pp, ld_user, {ADDR_W{1'b0}}};
                        harq_rd_addr_q  <= {ld_user, {ADDR_W{1'b0}}};
                        cnt_q           <= ADDR_W'(1);
                    end
                end
                StRead: begin
                    if (cnt_q == num_q) begin
                        state_q       <= StDrain;
                        inbuf_rd_en_q <= 1'b0;
                        harq_rd_en_q  <= 1'b0;
                        drain_q       <= 1'b0;
                    end else begin
                        inbuf_rd_addr_q <= {pp_q, user_q, cnt_q};
                        harq_rd_addr_q  <= {user_q, cnt_q};
                        cnt_q           <= cnt_q + 1'b1;
                    end
                end
                StDrain: begin
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        state_q <= StDone;
                        comp_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StWaitRel;
                end
                StWaitRel: begin
                    if (!i_combine_process_request) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    harq_llr_sat_adder #(
        .LLR_W        (LLR_W),
        .LLR_PER_WORD (LLR_PER_WORD)
    ) u_sat_adder (
        .i_core_clk (i_core_clk),
        .i_rx_rstn  (i_rx_rstn),
        .i_bypass   (first_q),
        .i_llr_new  (i_inbuf_rd_data),
        .i_llr_old  (i_harq_rd_data),
        .o_llr_sum  (o_harq_wr_data)
    );

    assign o_inbuf_rd_en             = inbuf_rd_en_q;
    assign o_inbuf_rd_addr           = inbuf_rd_addr_q;
    assign o_harq_rd_en              = harq_rd_en_q;
    assign o_harq_rd_addr            = harq_rd_addr_q;
    assign o_harq_wr_en              = wr_en_q;
    assign o_harq_wr_addr            = wr_addr_q;
    assign o_current_cb_combine_comp = comp_q;
    assign o_err_bad_user            = err_q;
    assign o_busy                    = (state_q != StIdle);

endmodule
